// File: rtl/bcd_display_converter_if.sv
// Handshake and result bundle between the sample averager, the BCD converter
// and the seven-segment display driver.
interface bcd_display_converter_if #(
  parameter int N      = 12,
  parameter int DIGITS = 4
);
  logic [N-1:0]        din;
  logic                valid_in;
  logic                ready;
  logic [4*DIGITS-1:0] bcd;
  logic                done;
  logic                overrun;

  // Upstream side: offers samples and observes the result.
  modport master (
    output din, valid_in,
    input  ready, bcd, done, overrun
  );

  // Converter side.
  modport slave (
    input  din, valid_in,
    output ready, bcd, done, overrun
  );
endinterface

// File: rtl/bcd_display_converter.sv
// Sequential binary-to-BCD converter (shift-add-3, one shift per clock).
// Accepts a sample when idle, produces packed BCD after N enabled cycles and
// holds it until the next conversion completes.
// Optional macro SCALE_MV_EN: scale the captured sample to millivolts,
// (din * VREF_MV) >> N, before conversion.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | ready high, waiting for valid_in
// CONVERT | shifting; count holds the number of shifts still to do
module bcd_display_converter #(
  parameter int N       = 12,
  parameter int DIGITS  = 4,
  parameter int VREF_MV = 3300
) (
  input logic                     clk,
  input logic                     reset_n,
  input logic                     EN,
  bcd_display_converter_if.slave  bus
);

  localparam int CW = $clog2(N + 1);
  localparam int BW = 4 * DIGITS;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_CONVERT = 1'b1;

  // The scratch register must hold every N-bit value without overflow.
  if (10 ** DIGITS <= 2 ** N) begin : g_bad_digits
    $error("bcd_display_converter: DIGITS too small for N");
  end
  if (VREF_MV >= 2 ** N) begin : g_bad_vref
    $error("bcd_display_converter: VREF_MV must be below 2**N");
  end

  logic [0:0]    state;
  logic [N-1:0]  bin;
  logic [BW-1:0] scratch;
  logic [CW-1:0] count;
  logic [BW-1:0] bcd_q;
  logic          done_q;
  logic          overrun_q;
  logic [BW-1:0] adj;
  logic [BW-1:0] scratch_next;
  logic [N-1:0]  cap_val;

`ifdef SCALE_MV_EN
  localparam int VW = $clog2(VREF_MV + 1);
  logic [N+VW-1:0] prod;
  // Full-width product, then drop the fractional N bits.
  always_comb begin
    prod    = {{VW{1'b0}}, bus.din} * (N+VW)'(VREF_MV);
    cap_val = N'(prod >> N);
  end
`else
  // Raw ADC counts go straight into the converter.
  always_comb begin
    cap_val = bus.din;
  end
`endif

  // Add 3 to each digit >= 5 so the following shift carries correctly in BCD.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
    scratch_next = {adj[BW-2:0], bin[N-1]};
  end

  // Handshake FSM, shift datapath and registered result/pulse outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      bin       <= '0;
      scratch   <= '0;
      count     <= '0;
      bcd_q     <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else if (!EN) begin
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.valid_in) begin
            bin     <= cap_val;
            scratch <= '0;
            count   <= CW'(N);
            state   <= ST_CONVERT;
          end
        end
        default: begin
          // Samples offered while busy are dropped; the display only needs
          // periodic updates.
          if (bus.valid_in) begin
            overrun_q <= 1'b1;
          end
          scratch <= scratch_next;
          bin     <= {bin[N-2:0], 1'b0};
          count   <= count - CW'(1);
          if (count == CW'(1)) begin
            bcd_q  <= scratch_next;
            done_q <= 1'b1;
            state  <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.ready   = (state == ST_IDLE);
  assign bus.bcd     = bcd_q;
  assign bus.done    = done_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_bcd_display_converter.sv
// Scoreboard bench for bcd_display_converter: stimulus pushes the expected BCD
// word when it issues a sample; a monitor pops and compares on every done.
module tb_bcd_display_converter;
  localparam int N      = 12;
  localparam int DIGITS = 4;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic EN      = 1'b1;

  bcd_display_converter_if #(.N(N), .DIGITS(DIGITS)) bus ();

  bcd_display_converter #(.N(N), .DIGITS(DIGITS), .VREF_MV(3300)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .EN      (EN),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int n_done   = 0;
  int done_cyc = 0;
  int ov_cnt   = 0;
  int cap_cyc  = 0;
  logic [15:0] exp_q[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: pop expected result on every done pulse.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.overrun) ov_cnt++;
      if (bus.done) begin
        n_done++;
        done_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          chk("bcd_result", int'(bus.bcd), int'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic wait_ready();
    for (int k = 0; k < 100; k++) begin
      if (bus.ready) return;
      @(negedge clk); #1;
    end
    chk("ready_timeout", 0, 1);
  endtask

  task automatic start(input logic [11:0] d, input logic [15:0] exp);
    wait_ready();
    bus.din      = d;
    bus.valid_in = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    cap_cyc      = cyc;
    bus.valid_in = 1'b0;
  endtask

  task automatic wait_done(input int n0);
    for (int k = 0; k < 100; k++) begin
      if (n_done > n0) return;
      @(negedge clk); #1;
    end
    chk("done_timeout", 0, 1);
  endtask

  int n0, d1, lows, ov0;

  initial begin
    bus.din      = '0;
    bus.valid_in = 1'b0;
    #22 reset_n = 1'b1;
    #1;
    chk("por_ready", int'(bus.ready), 1);
    chk("por_bcd", int'(bus.bcd), 0);
    chk("por_done", int'(bus.done), 0);
    chk("por_overrun", int'(bus.overrun), 0);

`ifdef SCALE_MV_EN
    n0 = n_done; start(12'd4095, 16'h3299); wait_done(n0);
    chk("mv_latency", done_cyc - cap_cyc, 12);
    n0 = n_done; start(12'd2048, 16'h1650); wait_done(n0);
    chk("mv_latency", done_cyc - cap_cyc, 12);
    n0 = n_done; start(12'd1, 16'h0000); wait_done(n0);
    chk("mv_latency", done_cyc - cap_cyc, 12);
    chk("mv_done_count", n_done - n0, 1);
`else
    // Single conversion: ready low for N cycles, done N edges after capture.
    n0 = n_done;
    start(12'd1234, 16'h1234);
    lows = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk); #1;
      if (bus.ready) break;
      lows++;
    end
    chk("busy_cycles", lows, 12);
    wait_done(n0);
    chk("latency_1234", done_cyc - cap_cyc, 12);

    // Back-to-back: done pulses N+1 cycles apart.
    n0 = n_done; start(12'd4095, 16'h4095); wait_done(n0);
    d1 = done_cyc;
    n0 = n_done; start(12'd0, 16'h0000); wait_done(n0);
    chk("done_spacing", done_cyc - d1, 13);
    chk("bcd_hold_zero", int'(bus.bcd), 0);

    // Continuous valid_in: captures every 13 edges, drops counted as overrun.
    wait_ready();
    ov0 = ov_cnt;
    n0  = n_done;
    exp_q.push_back(16'h0100);
    exp_q.push_back(16'h0113);
    exp_q.push_back(16'h0126);
    exp_q.push_back(16'h0139);
    for (int k = 0; k < 40; k++) begin
      bus.din      = 12'(100 + k);
      bus.valid_in = 1'b1;
      @(posedge clk); #1;
    end
    bus.valid_in = 1'b0;
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) begin
      @(negedge clk); #1;
    end
    chk("stream_queue_empty", exp_q.size(), 0);
    chk("stream_done_count", n_done - n0, 4);
    chk("stream_overruns", ov_cnt - ov0, 36);

    // EN low for 5 cycles mid-conversion stretches latency by 5.
    n0 = n_done;
    start(12'd777, 16'h0777);
    repeat (6) @(posedge clk);
    #1 EN = 1'b0;
    repeat (5) @(posedge clk);
    #1 EN = 1'b1;
    wait_done(n0);
    chk("latency_en_gap", done_cyc - cap_cyc, 17);

    // Reset during the conversion: abandoned, bcd cleared, no done.
    n0 = n_done;
    start(12'd999, 16'h0999);
    repeat (6) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_bcd_cleared", int'(bus.bcd), 0);
    exp_q.delete();
    #2 reset_n = 1'b1;
    #1;
    chk("rst_ready", int'(bus.ready), 1);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_overrun", int'(bus.overrun), 0);
    repeat (20) @(negedge clk);
    #1;
    chk("rst_no_done", n_done - n0, 0);
    chk("rst_bcd_held", int'(bus.bcd), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
